// File: rtl/pcla_pkg.sv
// pcla_pkg: shared types and elaboration helpers for the pipelined CLA adder.
// stage_ctl_t travels with each operation: valid, stage carry, operand sign bits.
package pcla_pkg;

  localparam int PCLA_MIN_BLOCK = 2;

  typedef struct packed {
    logic valid;
    logic carry;
    logic a_msb;
    logic b_msb;
  } stage_ctl_t;

  function automatic int pcla_stages(
    input int width,
    input int block
  );
    return width / block;
  endfunction

  function automatic bit pcla_cfg_ok(
    input int width,
    input int block
  );
    return (block >= PCLA_MIN_BLOCK) && (width % block == 0);
  endfunction

endpackage

// File: rtl/cla_block.sv
// cla_block: combinational BLOCK-bit carry-lookahead slice.
// Ports: a, b, ci in; s, co, group propagate grp_p, group generate grp_g out.
module cla_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             grp_p,
  output logic             grp_g
);

  logic [BLOCK-1:0] gi;
  logic [BLOCK-1:0] pi;
  logic [BLOCK:0]   c;
  logic             acc;
  logic             prod;

  // Every carry is a flat sum of products over the lower bits,
  // so no carry depends on another carry inside the slice.
  always_comb begin
    gi = a & b;
    pi = a ^ b;
    c = '0;
    c[0] = ci;
    acc = 1'b0;
    prod = 1'b1;
    for (int i = 0; i < BLOCK; i++) begin
      acc = 1'b0;
      prod = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc = acc | (gi[j] & prod);
        prod = prod & pi[j];
      end
      c[i+1] = acc | (prod & ci);
    end
    grp_g = acc;
    grp_p = prod;
  end

  assign s  = pi ^ c[BLOCK-1:0];
  assign co = c[BLOCK];

endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: add/sub unit, one BLOCK-bit CLA slice per stage.
// Ports: valid/ready in (a,b,cin,sub), valid/ready out (sum,cout,ovf); zero with PCLA_ZERO_FLAG_EN.
module pipelined_cla_adder
  import pcla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
`ifdef PCLA_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int STAGES = pcla_stages(WIDTH, BLOCK);

  if (!pcla_cfg_ok(WIDTH, BLOCK)) begin : g_bad_cfg
    $error("pipelined_cla_adder: WIDTH must be a multiple of BLOCK >= 2");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Chunk [k][j] holds bits [j*BLOCK +: BLOCK] in the register after stage k.
  // a_sk/b_sk carry unresolved chunks (j > k); ds carries resolved sum (j <= k).
  logic [BLOCK-1:0] a_sk [STAGES][STAGES];
  logic [BLOCK-1:0] b_sk [STAGES][STAGES];
  logic [BLOCK-1:0] ds   [STAGES][STAGES];
  stage_ctl_t       ctl_q [STAGES];

  logic [BLOCK-1:0]  op_a  [STAGES];
  logic [BLOCK-1:0]  op_b  [STAGES];
  logic [BLOCK-1:0]  s_blk [STAGES];
  logic [STAGES-1:0] ci;
  logic [STAGES-1:0] co;
  logic [STAGES-1:0] unused_grp_p;
  logic [STAGES-1:0] unused_grp_g;

  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;
  assign b_eff    = sub ? ~b : b;
  assign c_eff    = sub ? ~cin : cin;

  always_comb begin
    op_a[0] = a[BLOCK-1:0];
    op_b[0] = b_eff[BLOCK-1:0];
    ci      = '0;
    ci[0]   = c_eff;
    for (int k = 1; k < STAGES; k++) begin
      op_a[k] = a_sk[k-1][k];
      op_b[k] = b_sk[k-1][k];
      ci[k]   = ctl_q[k-1].carry;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    cla_block #(
      .BLOCK(BLOCK)
    ) u_cla (
      .a    (op_a[k]),
      .b    (op_b[k]),
      .ci   (ci[k]),
      .s    (s_blk[k]),
      .co   (co[k]),
      .grp_p(unused_grp_p[k]),
      .grp_g(unused_grp_g[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl_q[k] <= '0;
        for (int j = 0; j < STAGES; j++) begin
          a_sk[k][j] <= '0;
          b_sk[k][j] <= '0;
          ds[k][j]   <= '0;
        end
      end
    end else if (advance) begin
      ctl_q[0] <= '{
        valid: in_valid,
        carry: co[0],
        a_msb: a[WIDTH-1],
        b_msb: b_eff[WIDTH-1]
      };
      ds[0][0] <= s_blk[0];
      for (int j = 1; j < STAGES; j++) begin
        a_sk[0][j] <= a[j*BLOCK +: BLOCK];
        b_sk[0][j] <= b_eff[j*BLOCK +: BLOCK];
      end
      for (int k = 1; k < STAGES; k++) begin
        ctl_q[k] <= '{
          valid: ctl_q[k-1].valid,
          carry: co[k],
          a_msb: ctl_q[k-1].a_msb,
          b_msb: ctl_q[k-1].b_msb
        };
        for (int j = 0; j < k; j++) begin
          ds[k][j] <= ds[k-1][j];
        end
        ds[k][k] <= s_blk[k];
        for (int j = k + 1; j < STAGES; j++) begin
          a_sk[k][j] <= a_sk[k-1][j];
          b_sk[k][j] <= b_sk[k-1][j];
        end
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int j = 0; j < STAGES; j++) begin
      sum[j*BLOCK +: BLOCK] = ds[STAGES-1][j];
    end
  end

  assign out_valid = ctl_q[STAGES-1].valid;
  assign cout      = ctl_q[STAGES-1].carry;
  // All terms are registered and reset to 0, so ovf is 0 in reset too.
  assign ovf = (ctl_q[STAGES-1].a_msb == ctl_q[STAGES-1].b_msb)
             & (sum[WIDTH-1] != ctl_q[STAGES-1].a_msb);

`ifdef PCLA_ZERO_FLAG_EN
  // Running all-zero flag, one slice ANDed in per stage.
  logic [STAGES-1:0] z_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= '0;
    end else if (advance) begin
      z_q[0] <= ~|s_blk[0];
      for (int k = 1; k < STAGES; k++) begin
        z_q[k] <= z_q[k-1] & ~|s_blk[k];
      end
    end
  end

  assign zero = z_q[STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: vector table, stall, reset and random scoreboard bench.
// Reference results come from exact signed/unsigned integer arithmetic.
module tb_pipelined_cla_adder;

  localparam int W = 32;
  localparam int S = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
`ifdef PCLA_ZERO_FLAG_EN
  logic         zero;
`endif

  int   checks = 0;
  int   fails = 0;
  int   pops = 0;
  exp_t sb_q[$];

  pipelined_cla_adder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
`ifdef PCLA_ZERO_FLAG_EN
    ,
    .zero     (zero)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic exp_t model(
    input logic [W-1:0] ma,
    input logic [W-1:0] mb,
    input logic         mc,
    input logic         ms
  );
    exp_t   e;
    longint sa, sb, ex, ua, ub, c;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ua = {32'd0, ma};
    ub = {32'd0, mb};
    c  = mc ? 64'd1 : 64'd0;
    if (ms) begin
      ex = sa - sb - c;
      e.cout = (ua >= ub + c);
    end else begin
      ex = sa + sb + c;
      e.cout = (ua + ub + c) >= 64'sd4294967296;
    end
    e.sum = ex[W-1:0];
    e.ovf = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
    return e;
  endfunction

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL sb_unexpected: got out_valid=1 sum=0x%0h expected no output", sum);
        end else begin
          chk("sb_sum", 64'(sum), 64'(sb_q[0].sum));
          chk("sb_cout", 64'(cout), 64'(sb_q[0].cout));
          chk("sb_ovf", 64'(ovf), 64'(sb_q[0].ovf));
`ifdef PCLA_ZERO_FLAG_EN
          chk("sb_zero", 64'(zero), 64'(sb_q[0].sum == '0));
`endif
          if (out_ready) begin
            void'(sb_q.pop_front());
            pops++;
          end
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(a, b, cin, sub));
      end
    end
  end

  task automatic put(
    input logic [W-1:0] ta,
    input logic [W-1:0] tb2,
    input logic         tc,
    input logic         ts
  );
    bit done = 1'b0;
    a = ta;
    b = tb2;
    cin = tc;
    sub = ts;
    in_valid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    chk("put_accepted", 64'(done), 64'd1);
  endtask

  vec_t vecs[8];

  initial begin
    int lat;
    int start;
    int stale;
    int sent;
    bit xfer;

    vecs[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000006, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{32'h00FFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h01000000, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
`ifdef PCLA_ZERO_FLAG_EN
    chk("rst_zero", 64'(zero), 64'd0);
`endif
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, one at a time, with latency measurement.
    foreach (vecs[i]) begin
      put(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      in_valid = 1'b0;
      lat = -1;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (out_valid) begin
          lat = n;
          break;
        end
      end
      chk("vec_latency", 64'(lat), 64'(S - 1));
      chk("vec_sum", 64'(sum), 64'(vecs[i].sum));
      chk("vec_cout", 64'(cout), 64'(vecs[i].cout));
      chk("vec_ovf", 64'(ovf), 64'(vecs[i].ovf));
`ifdef PCLA_ZERO_FLAG_EN
      chk("vec_zero", 64'(zero), 64'(vecs[i].zero));
`endif
      @(posedge clk);
      #1;
    end

    // Back-to-back stream with a 3-cycle output stall before item 6.
    start = pops;
    for (int i = 1; i <= 8; i++) begin
      if (i == 6) begin
        a = W'(i);
        b = W'(i);
        in_valid = 1'b1;
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("stall_out_valid", 64'(out_valid), 64'd1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
      put(W'(i), W'(i), 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    for (int n = 0; n < 40 && sb_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    chk("stream_count", 64'(pops - start), 64'd8);

    // Random traffic with random bubbles and back-pressure.
    sent = 0;
    for (int cyc = 0; cyc < 5000 && sent < 200; cyc++) begin
      @(negedge clk);
      xfer = in_valid && in_ready;
      if (xfer) sent++;
      @(posedge clk);
      #1;
      if (!in_valid || xfer) begin
        if ($urandom_range(3) != 0) begin
          case ($urandom_range(5))
            0: a = 32'hFFFFFFFF;
            1: a = 32'h80000000;
            default: a = $urandom;
          endcase
          b = ($urandom_range(5) == 0) ? 32'h7FFFFFFF : $urandom;
          cin = 1'($urandom_range(1));
          sub = 1'($urandom_range(1));
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(3) != 0);
    end
    chk("rand_sent", 64'(sent), 64'd200);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 40 && sb_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 64'(sb_q.size()), 64'd0);

    // Asynchronous reset with one result at the output and three in flight.
    out_ready = 1'b0;
    put(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    put(32'h00000011, 32'h00000022, 1'b0, 1'b0);
    put(32'h00000033, 32'h00000044, 1'b0, 1'b0);
    put(32'h00000055, 32'h00000066, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_out_valid", 64'(out_valid), 64'd0);
    chk("areset_sum", 64'(sum), 64'd0);
    chk("areset_cout", 64'(cout), 64'd0);
    chk("areset_ovf", 64'(ovf), 64'd0);
`ifdef PCLA_ZERO_FLAG_EN
    chk("areset_zero", 64'(zero), 64'd0);
`endif
    sb_q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("stale_after_reset", 64'(stale), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
